// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// datapath select codes and the per-state Moore output table.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR_ADR,
    S_JALR_PC,
    S_LUI,
    S_ERROR
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } alu_op_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10,
    RES_IMMEXT    = 2'b11
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_A     = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_WDATA = 2'b00,
    SRCB_IMM   = 2'b01,
    SRCB_FOUR  = 2'b10
  } src_b_t;

  typedef struct packed {
    logic        adr_src;
    result_src_t result_src;
    src_a_t      alu_src_a;
    src_b_t      alu_src_b;
    alu_op_t     alu_op;
    logic        reg_write;
    logic        trap;
  } moore_out_t;

  // Outputs that depend on the state alone; the strobes gated by zero or
  // mem_ready are produced separately in the top.
  function automatic moore_out_t moore_outs(input state_t s);
    moore_out_t o;
    o.adr_src    = 1'b0;
    o.result_src = RES_ALUOUT;
    o.alu_src_a  = SRCA_PC;
    o.alu_src_b  = SRCB_WDATA;
    o.alu_op     = ALUOP_ADD;
    o.reg_write  = 1'b0;
    o.trap       = 1'b0;
    case (s)
      S_FETCH: begin
        o.alu_src_b  = SRCB_FOUR;
        o.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        o.alu_src_a = SRCA_OLDPC;
        o.alu_src_b = SRCB_IMM;
      end
      S_MEMADR, S_JALR_ADR: begin
        o.alu_src_a = SRCA_A;
        o.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD, S_MEMWRITE: o.adr_src = 1'b1;
      S_MEMWB: begin
        o.result_src = RES_DATA;
        o.reg_write  = 1'b1;
      end
      S_EXEC_R: begin
        o.alu_src_a = SRCA_A;
        o.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        o.alu_src_a = SRCA_A;
        o.alu_src_b = SRCB_IMM;
        o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: o.reg_write = 1'b1;
      S_BRANCH: begin
        o.alu_src_a = SRCA_A;
        o.alu_op    = ALUOP_SUB;
      end
      S_JAL, S_JALR_PC: begin
        o.alu_src_a = SRCA_OLDPC;
        o.alu_src_b = SRCB_FOUR;
      end
      S_LUI: begin
        o.result_src = RES_IMMEXT;
        o.reg_write  = 1'b1;
      end
      S_ERROR: o.trap = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic imm_src_t imm_src_of(input logic [6:0] op);
    imm_src_t r;
    case (op)
      OP_STORE:          r = IMM_S;
      OP_BRANCH:         r = IMM_B;
      OP_JAL:            r = IMM_J;
      OP_LUI, OP_AUIPC:  r = IMM_U;
      default:           r = IMM_I;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus funct fields to the ALU control code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_is_rtype,
  output alu_ctrl_t  o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // instr[30] is part of the immediate for addi, so SUB is R-type only
          3'b000:  o_alu_control = (i_is_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_control = ALU_SLL;
          3'b010:  o_alu_control = ALU_SLT;
          3'b011:  o_alu_control = ALU_SLTU;
          3'b100:  o_alu_control = ALU_XOR;
          3'b101:  o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_control = ALU_OR;
          default: o_alu_control = ALU_AND;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencer for the multicycle RV32I datapath: state register, next-state
// logic, registered Moore selects and handshake/flag-gated strobes.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int HANDSHAKE_EN = 1,
  parameter int ALU_CTRL_W   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [6:0]            i_op,
  input  logic [2:0]            i_funct3,
  input  logic                  i_funct7b5,
  input  logic                  i_zero,
  input  logic                  i_mem_ready,
  output logic                  o_pc_write,
  output logic                  o_adr_src,
  output logic                  o_mem_write,
  output logic                  o_ir_write,
  output logic [1:0]            o_result_src,
  output logic [1:0]            o_alu_src_a,
  output logic [1:0]            o_alu_src_b,
  output logic [2:0]            o_imm_src,
  output logic [ALU_CTRL_W-1:0] o_alu_control,
  output logic                  o_reg_write,
  output logic                  o_retire,
  output logic                  o_trap
);

  state_t     r_state;
  state_t     w_state_next;
  moore_out_t r_outs;
  logic       w_ready;
  logic       w_branch_take;
  alu_ctrl_t  w_alu_ctrl;

  assign w_ready       = (HANDSHAKE_EN != 0) ? i_mem_ready : 1'b1;
  assign w_branch_take = (i_funct3 == F3_BNE) ? ~i_zero : i_zero;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:    w_state_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_op)
          OP_LOAD, OP_STORE: w_state_next = (i_funct3 == F3_WORD) ? S_MEMADR : S_ERROR;
          OP_R:              w_state_next = S_EXEC_R;
          OP_I:              w_state_next = S_EXEC_I;
          OP_BRANCH:         w_state_next = (i_funct3 == F3_BEQ || i_funct3 == F3_BNE) ?
                                            S_BRANCH : S_ERROR;
          OP_JAL:            w_state_next = S_JAL;
          OP_JALR:           w_state_next = S_JALR_ADR;
          OP_LUI:            w_state_next = S_LUI;
          OP_AUIPC:          w_state_next = S_ALUWB;
          default:           w_state_next = S_ERROR;
        endcase
      end
      S_MEMADR:   w_state_next = (i_op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_state_next = w_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_state_next = S_FETCH;
      S_MEMWRITE: w_state_next = w_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC_R:   w_state_next = S_ALUWB;
      S_EXEC_I:   w_state_next = S_ALUWB;
      S_ALUWB:    w_state_next = S_FETCH;
      S_BRANCH:   w_state_next = S_FETCH;
      S_JAL:      w_state_next = S_ALUWB;
      S_JALR_ADR: w_state_next = S_JALR_PC;
      S_JALR_PC:  w_state_next = S_ALUWB;
      S_LUI:      w_state_next = S_FETCH;
      S_ERROR:    w_state_next = S_ERROR;
      default:    w_state_next = S_ERROR;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_FETCH;
      r_outs  <= moore_outs(S_FETCH);
    end else begin
      r_state <= w_state_next;
      r_outs  <= moore_outs(w_state_next);
    end
  end

  // Strobes follow the live mem_ready/zero inputs and are killed by reset at once.
  always_comb begin
    o_pc_write  = 1'b0;
    o_ir_write  = 1'b0;
    o_mem_write = 1'b0;
    o_retire    = 1'b0;
    if (!i_reset) begin
      case (r_state)
        S_FETCH: begin
          o_pc_write = w_ready;
          o_ir_write = w_ready;
        end
        S_BRANCH: begin
          o_pc_write = w_branch_take;
          o_retire   = 1'b1;
        end
        S_JAL, S_JALR_PC: o_pc_write = 1'b1;
        S_MEMWRITE: begin
          o_mem_write = 1'b1;
          o_retire    = w_ready;
        end
        S_MEMWB, S_ALUWB, S_LUI: o_retire = 1'b1;
        default: ;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (r_outs.alu_op),
    .i_funct3      (i_funct3),
    .i_funct7b5    (i_funct7b5),
    .i_is_rtype    (i_op == OP_R),
    .o_alu_control (w_alu_ctrl)
  );

  assign o_adr_src     = r_outs.adr_src;
  assign o_result_src  = r_outs.result_src;
  assign o_alu_src_a   = r_outs.alu_src_a;
  assign o_alu_src_b   = r_outs.alu_src_b;
  assign o_imm_src     = imm_src_of(i_op);
  assign o_alu_control = ALU_CTRL_W'(w_alu_ctrl);
  assign o_reg_write   = r_outs.reg_write & ~i_reset;
  assign o_trap        = r_outs.trap;

endmodule
